// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage MIPS core: stall-vector merge, exception/eret
// flush sequencing, MEM-stall watchdog and a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        exc_valid,
  input  logic        exc_eret,
  input  logic [31:0] epc,
  output logic [5:0]  stop,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        timeout_exc,
  output logic [31:0] stall_cycles
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_flush_cnt;
  logic [3:0]  w_flush_cnt_nxt;
  logic [7:0]  r_wd_cnt;
  logic [7:0]  w_wd_cnt_nxt;
  logic        r_flush;
  logic        w_flush_nxt;
  logic [31:0] r_new_pc;
  logic [31:0] w_new_pc_nxt;
  logic        r_timeout;
  logic        w_timeout_nxt;
  logic [31:0] r_stall_cnt;
  logic        w_wd_fire;
  logic [5:0]  w_stop;

  // Stall requests are ignored while flushing and while reset is asserted.
  always_comb begin
    w_stop = 6'b000000;
    if (rst_n && (r_state == RUN)) begin
      if (stallreq_mem)     w_stop = 6'b011111;
      else if (stallreq_ex) w_stop = 6'b001111;
      else if (stallreq_id) w_stop = 6'b000111;
    end
  end

  assign w_wd_fire = (r_state == RUN) && stallreq_mem && (r_wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_flush_cnt <= 4'd0;
      r_wd_cnt    <= 8'd0;
      r_flush     <= 1'b0;
      r_new_pc    <= 32'd0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_wd_cnt    <= w_wd_cnt_nxt;
      r_flush     <= w_flush_nxt;
      r_new_pc    <= w_new_pc_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  // Watchdog count only survives consecutive MEM stalls in RUN; anything else clears it.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_flush_nxt     = r_flush;
    w_new_pc_nxt    = r_new_pc;
    w_timeout_nxt   = 1'b0;
    w_wd_cnt_nxt    = 8'd0;
    case (r_state)
      RUN: begin
        w_timeout_nxt = w_wd_fire;
        if (exc_valid || w_wd_fire) begin
          w_state_nxt     = FLUSH;
          w_flush_nxt     = 1'b1;
          w_flush_cnt_nxt = FLUSH_LAST;
          w_new_pc_nxt    = (exc_valid && exc_eret) ? epc : EXC_VECTOR;
        end else if (stallreq_mem) begin
          w_wd_cnt_nxt = r_wd_cnt + 8'd1;
        end
      end
      FLUSH: begin
        if (r_flush_cnt == 4'd0) begin
          w_state_nxt = RUN;
          w_flush_nxt = 1'b0;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 4'd1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
    end else if (w_stop[0] && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stop         = w_stop;
  assign flush        = r_flush;
  assign new_pc       = r_new_pc;
  assign timeout_exc  = r_timeout;
  assign stall_cycles = r_stall_cnt;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline control unit for the 5-stage MIPS core. It merges stall requests from the ID, EX and MEM stages into the 6-bit stop vector consumed by pc and the inter-stage registers. It sequences exception and eret flushes, supplying the redirect PC and a multi-cycle flush window. It also runs a MEM-stall watchdog and a saturating stall-cycle performance counter.

Parameters:
EXC_VECTOR, 32'h0000_0020, redirect target for any exception, including the internal timeout.
FLUSH_CYCLES, 2, number of consecutive cycles flush stays high per event, range 1..15.
TIMEOUT, 64, consecutive MEM-stall cycles before the watchdog fires, range 2..255.

Ports:
clk  input  1  clock
rst_n  input  1  reset: synchronous, active-low
stallreq_id  input  1  ID-stage stall request, e.g. load-use hazard
stallreq_ex  input  1  EX-stage stall request, e.g. multi-cycle divide
stallreq_mem  input  1  MEM-stage stall request, memory wait
exc_valid  input  1  exception or eret reported from MEM, single-cycle pulse
exc_eret  input  1  qualifies exc_valid: 1 = eret, 0 = exception
epc  input  32  return address used when exc_eret=1
stop  output  6  stall vector: [0] pc, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB; 1 = Stop, 0 = NoStop
flush  output  1  clear all pipeline registers; pc loads new_pc
new_pc  output  32  redirect address, valid while flush=1
timeout_exc  output  1  one-cycle pulse when the watchdog fires
stall_cycles  output  32  count of cycles with stop[0]=1, saturating

Behaviour:
- Reset (rst_n=0 at posedge): FSM = RUN, flush=0, new_pc=0, timeout_exc=0, stall_cycles=0, watchdog count=0, flush count=0.
- stop is combinational from the current state and requests. Priority: flush state > MEM > EX > ID.
  - State FLUSH: stop=6'b000000. All stall requests are ignored.
  - RUN with stallreq_mem=1: stop=6'b011111.
  - RUN with stallreq_ex=1 (MEM not requesting): stop=6'b001111.
  - RUN with stallreq_id=1 (MEM and EX not requesting): stop=6'b000111.
  - RUN with no request: stop=6'b000000.
  - During reset cycles: stop=6'b000000.
- FSM states: RUN, FLUSH.
  - RUN -> FLUSH on a posedge where exc_valid=1 or the watchdog fires.
    - Same edge: flush<=1, flush count <= FLUSH_CYCLES-1.
    - new_pc <= epc if (exc_valid && exc_eret); otherwise EXC_VECTOR.
    - Latency: flush is high on the cycle after exc_valid is sampled.
  - FLUSH: decrement the flush count each cycle. When the count is 0 at a posedge: flush<=0, go to RUN. flush is therefore high for exactly FLUSH_CYCLES cycles.
  - exc_valid arriving while in FLUSH is ignored: no retrigger, new_pc held.
- Watchdog (RUN only):
  - The count increments on each posedge with stallreq_mem=1.
  - It clears on any cycle with stallreq_mem=0 and on entry to FLUSH.
  - When the count reaches TIMEOUT-1 with stallreq_mem still high, the watchdog fires: timeout_exc=1 for one cycle, FLUSH is entered with new_pc=EXC_VECTOR, and the count clears.
  - If exc_valid and the watchdog fire on the same edge, exc_valid wins for new_pc selection. timeout_exc still pulses.
- stall_cycles increments at each posedge where stop[0]=1 and holds at 32'hFFFF_FFFF. It is unaffected by flush.
- Reset mid-flush: returns immediately to the reset values. No residual flush.

Test Plan:
- Reset hold 3 cycles, then release with all inputs 0 -> stop=000000, flush=0, new_pc=0, stall_cycles=0.
- stallreq_id=1 for 2 cycles, then stallreq_ex=1 and stallreq_mem=1 together for 1 cycle -> stop=000111, 000111, then 011111; stall_cycles=3.
- exc_valid=1, exc_eret=0 at cycle N with stallreq_ex=1 -> stop=001111 at N; flush=1 at N+1 and N+2 (FLUSH_CYCLES=2), new_pc=32'h20, stop=000000 during the window; flush=0 at N+3.
- exc_valid=1, exc_eret=1, epc=32'h0000_1234; second exc_valid during the flush window -> new_pc=32'h1234, flush width stays 2 cycles, no retrigger.
- stallreq_mem held high 64 cycles (TIMEOUT=64) -> timeout_exc pulses once on cycle 64, flush follows with new_pc=32'h20. Variant: drop stallreq_mem at cycle 63 -> no pulse.
- Assert rst_n=0 during the first flush cycle -> flush=0 on the next cycle, FSM=RUN, stall_cycles=0.
